bus_burst_slave: RTL and testbench
==================================

Name: bus_burst_slave

Overview:
- Memory-mapped burst responder (slave) for the shared 32-bit multiplexed address/data bus driven by our DMA and CPU initiators.
- Holds a local word array and answers single and burst reads and writes addressed to its window.
- Drives read data, end-of-transaction and error back to the initiator, and stalls writes through busy_out.
- Sits on the bus beside the SDRAM controller as a fast scratch memory for DMA tests and data staging.

Parameters:
BASE_ADDRESS, 32'h5000_0000, window base; must be aligned to 4*2^ADDR_BITS bytes
ADDR_BITS, 10, word-address width; window holds 2^ADDR_BITS 32-bit words

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
begin_transaction_in  input  1  initiator starts a transaction (one-cycle pulse)
end_transaction_in  input  1  initiator ends or aborts a transaction
data_valid_in  input  1  write beat valid on address_data_in
read_n_write_in  input  1  1 = read, 0 = write; sampled with begin
address_data_in  input  32  address during begin, write data otherwise
burst_size_in  input  8  beats minus 1; sampled with begin
byte_enables_in  input  4  per-byte write enables; bit i covers data[8i+7:8i]
address_data_out  output  32  read data; 0 when not driving
data_valid_out  output  1  read beat valid
end_transaction_out  output  1  slave-side end of a read or error
busy_out  output  1  write beat not accepted this cycle
error_out  output  1  bus error, one-cycle pulse

Behaviour:
- Reset: state IDLE. All outputs 0. Internal address and beat counters cleared. Array contents are not cleared. Reset mid-transaction aborts on the next edge.
- Selection: begin_transaction_in=1 in IDLE with address_data_in[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]. Unselected begins are ignored and the block stays in IDLE.
- On a selected begin:
  - latch waddr = address_data_in[ADDR_BITS+1:2]
  - latch beats = burst_size_in + 1 (9-bit, range 1..256)
  - latch rnw = read_n_write_in
- Error check at begin. Go to ERR if either holds:
  - address_data_in[1:0] != 0
  - waddr + burst_size_in > 2^ADDR_BITS - 1 (window overrun; computed at ADDR_BITS+1 bits, so no wrap)
- Otherwise go to WR (rnw=0) or RD (rnw=1).
- Begin pulses in any state other than IDLE are ignored.
- States:
  - IDLE: wait for a selected begin.
  - WR: each cycle with data_valid_in=1 and busy_out=0 is one accepted beat. Byte-wise write of mem[waddr] per byte_enables_in, then waddr+1, beats-1. Beats arriving after beats reaches 0 are dropped (no write). end_transaction_in=1 returns to IDLE next edge, including an early end (remaining beats abandoned). A beat with both data_valid_in and end_transaction_in set in the same cycle is accepted, then IDLE.
  - RD: outputs are registered. On the edge entering RD, nothing is driven yet. On each following edge, drive address_data_out=mem[waddr] with data_valid_out=1, then waddr+1, beats-1. The first beat is visible 2 edges after begin is sampled, and beats are back-to-back. After the last beat, go to RDEND.
  - end_transaction_in=1 during RD aborts: outputs 0 on the next edge, state IDLE, no end_transaction_out.
  - RDEND: one cycle with end_transaction_out=1, data_valid_out=0, address_data_out=0, then IDLE.
  - ERR: one cycle with error_out=1, end_transaction_out=1, no array access, then IDLE.
- address_data_out is 0 whenever data_valid_out=0. busy_out is 0 outside WR.
- Read during write: not possible (single transaction at a time).

Optional Feature:
Macro BUS_SLAVE_WAIT_STATES_EN.
- Defined: in WR, busy_out alternates. It is 1 in the first WR cycle and after every accepted beat, so each beat takes 2 cycles. In RD, one idle cycle (data_valid_out=0) is inserted between beats.
- Not defined: busy_out is constant 0 and reads stream back-to-back.
- All other behaviour is identical in both builds.

Test Plan:
- Write then read: write begin addr 0x5000_0010, burst 3, data 0x11,0x22,0x33,0x44, BE=F, then end; read begin same address, burst 3 -> 4 beats 0x11,0x22,0x33,0x44 on consecutive cycles starting 2 edges after begin, then end_transaction_out for 1 cycle.
- Byte enables: mem[0]=0xAABBCCDD; write 0x11223344 with BE=4'b0101 -> read gives 0xAA22CC44.
- Window overrun: begin at word 1020 (0x5000_0FF0), burst 7, ADDR_BITS=10 -> error_out=1 and end_transaction_out=1 one cycle later; array unchanged; no data_valid_out.
- Misaligned or foreign address: begin 0x5000_0002 -> error; begin 0x4000_0000 -> no response, all outputs stay 0.
- Abort and reset: read burst 15 aborted by end_transaction_in after the 3rd beat -> data_valid_out=0 next edge, no end_transaction_out; reset asserted mid-write after 2 of 4 beats -> IDLE, outputs 0, and the 2 written words persist.
- With BUS_SLAVE_WAIT_STATES_EN: 4-beat write held valid takes 8 cycles with busy_out toggling 1,0; 4-beat read shows beats on alternate cycles.

Source files
------------

// File: rtl/bus_burst_slave.sv
// bus_burst_slave: scratch-memory responder on the shared multiplexed
// address/data bus. Answers single and burst reads/writes that fall inside
// its window. Bad alignment and window overrun are answered with a one-cycle
// error. All bus outputs are registered.
// Build option: define BUS_SLAVE_WAIT_STATES_EN to insert one wait cycle per
// write beat (via busy_out) and one idle cycle between read beats.
module bus_burst_slave #(
  parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
  parameter int unsigned ADDR_BITS    = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        begin_transaction_in,
  input  logic        end_transaction_in,
  input  logic        data_valid_in,
  input  logic        read_n_write_in,
  input  logic [31:0] address_data_in,
  input  logic [7:0]  burst_size_in,
  input  logic [3:0]  byte_enables_in,
  output logic [31:0] address_data_out,
  output logic        data_valid_out,
  output logic        end_transaction_out,
  output logic        busy_out,
  output logic        error_out
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

`ifdef BUS_SLAVE_WAIT_STATES_EN
  localparam logic WAIT_STATES = 1'b1;
`else
  localparam logic WAIT_STATES = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_RD    = 3'd2,
    ST_RDEND = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  // Merge a new word into an old one, byte lane i taken from new when be[i].
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   waddr_q, waddr_d;
  logic [8:0]             beats_q, beats_d;
  logic                   gap_q, gap_d;
  logic [31:0]            rdata_q, rdata_d;
  logic                   dv_q, dv_d;
  logic                   eot_q, eot_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;

  logic [31:0]            mem_q [DEPTH];

  logic                   select_s;
  logic                   misaligned_s;
  logic                   overrun_s;
  logic                   accept_s;
  logic                   mem_we_s;
  logic [ADDR_BITS-1:0]   start_word_s;
  logic [ADDR_BITS:0]     span_s;
  logic [31:0]            rd_word_s;
  logic [31:0]            wr_word_s;

  // Address decode, begin-time error checks and array access words.
  always_comb begin
    select_s     = begin_transaction_in &&
                   (address_data_in[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2]);
    start_word_s = address_data_in[ADDR_BITS+1:2];
    misaligned_s = (address_data_in[1:0] != 2'b00);
    // One extra bit so the end-of-burst word cannot wrap back into the window.
    span_s       = {1'b0, start_word_s} + {{(ADDR_BITS-7){1'b0}}, burst_size_in};
    overrun_s    = span_s[ADDR_BITS];
    accept_s     = (state_q == ST_WR) && data_valid_in && !busy_q;
    rd_word_s    = mem_q[waddr_q];
    wr_word_s    = merge_bytes(mem_q[waddr_q], address_data_in, byte_enables_in);
  end

  // Next-state and next-output logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    beats_d  = beats_q;
    gap_d    = gap_q;
    rdata_d  = 32'h0000_0000;
    dv_d     = 1'b0;
    eot_d    = 1'b0;
    busy_d   = 1'b0;
    err_d    = 1'b0;
    mem_we_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        gap_d = 1'b0;
        if (select_s) begin
          waddr_d = start_word_s;
          beats_d = {1'b0, burst_size_in} + 9'd1;
          if (misaligned_s || overrun_s) begin
            state_d = ST_ERR;
          end else if (read_n_write_in) begin
            state_d = ST_RD;
          end else begin
            state_d = ST_WR;
            // First write cycle is a wait cycle when wait states are enabled.
            busy_d  = WAIT_STATES;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR: begin
        // Beats beyond the announced burst length are accepted but dropped.
        if (accept_s && (beats_q != 9'd0)) begin
          mem_we_s = 1'b1;
          waddr_d  = waddr_q + ADDR_BITS'(1);
          beats_d  = beats_q - 9'd1;
        end else begin
          mem_we_s = 1'b0;
        end
        if (end_transaction_in) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_WR;
          busy_d  = WAIT_STATES & accept_s;
        end
      end

      ST_RD: begin
        if (end_transaction_in) begin
          // Abort: outputs fall to zero, no slave-side end.
          state_d = ST_IDLE;
          gap_d   = 1'b0;
        end else if (gap_q) begin
          gap_d = 1'b0;
        end else begin
          rdata_d = rd_word_s;
          dv_d    = 1'b1;
          waddr_d = waddr_q + ADDR_BITS'(1);
          beats_d = beats_q - 9'd1;
          gap_d   = WAIT_STATES;
          if (beats_q == 9'd1) begin
            state_d = ST_RDEND;
          end else begin
            state_d = ST_RD;
          end
        end
      end

      ST_RDEND: begin
        eot_d   = 1'b1;
        state_d = ST_IDLE;
      end

      ST_ERR: begin
        err_d   = 1'b1;
        eot_d   = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered bus outputs; reset aborts any transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      waddr_q <= {ADDR_BITS{1'b0}};
      beats_q <= 9'd0;
      gap_q   <= 1'b0;
      rdata_q <= 32'h0000_0000;
      dv_q    <= 1'b0;
      eot_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      waddr_q <= waddr_d;
      beats_q <= beats_d;
      gap_q   <= gap_d;
      rdata_q <= rdata_d;
      dv_q    <= dv_d;
      eot_q   <= eot_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Word array; contents survive reset, a write in a reset cycle is dropped.
  always_ff @(posedge clock) begin
    if (mem_we_s && !reset) begin
      mem_q[waddr_q] <= wr_word_s;
    end
  end

  assign address_data_out    = rdata_q;
  assign data_valid_out      = dv_q;
  assign end_transaction_out = eot_q;
  assign busy_out            = busy_q;
  assign error_out           = err_q;

endmodule

// File: tb/tb_bus_burst_slave.sv
// Scoreboard testbench for bus_burst_slave: a driver issues directed and
// random transactions and queues the expected responses from a word-array
// reference model; a negedge monitor pops and compares every DUT response.
module tb_bus_burst_slave;

`ifdef BUS_SLAVE_WAIT_STATES_EN
  localparam int   STEP = 2;
  localparam logic WS   = 1'b1;
`else
  localparam int   STEP = 1;
  localparam logic WS   = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h5000_0000;

  localparam int K_DATA = 0;
  localparam int K_END  = 1;
  localparam int K_ERR  = 2;

  typedef struct {
    int          kind;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  be;
  } wbeat_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        begin_transaction_in = 1'b0;
  logic        end_transaction_in = 1'b0;
  logic        data_valid_in = 1'b0;
  logic        read_n_write_in = 1'b0;
  logic [31:0] address_data_in = 32'h0;
  logic [7:0]  burst_size_in = 8'h0;
  logic [3:0]  byte_enables_in = 4'h0;
  logic [31:0] address_data_out;
  logic        data_valid_out;
  logic        end_transaction_out;
  logic        busy_out;
  logic        error_out;

  int checks = 0;
  int errs   = 0;
  int cyc    = 0;

  exp_t        sb_q[$];
  wbeat_t      dir_q[$];
  logic [31:0] model_mem [1024];

  bus_burst_slave #(.BASE_ADDRESS(BASE), .ADDR_BITS(10)) dut (
    .clock(clock), .reset(reset),
    .begin_transaction_in(begin_transaction_in),
    .end_transaction_in(end_transaction_in),
    .data_valid_in(data_valid_in),
    .read_n_write_in(read_n_write_in),
    .address_data_in(address_data_in),
    .burst_size_in(burst_size_in),
    .byte_enables_in(byte_enables_in),
    .address_data_out(address_data_out),
    .data_valid_out(data_valid_out),
    .end_transaction_out(end_transaction_out),
    .busy_out(busy_out),
    .error_out(error_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    check(name, {28'h0, address_data_out, data_valid_out, end_transaction_out, busy_out, error_out}, 64'h0);
  endtask

  // Reference write: byte lanes with enable set are replaced.
  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] be);
    for (int i = 0; i < 4; i++) begin
      if (be[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
    end
  endtask

  // Monitor: every response the DUT presents is matched against the scoreboard.
  always @(negedge clock) begin
    exp_t e;
    if (!data_valid_out) check("ado_idle_zero", address_data_out, 32'h0);
    if (data_valid_out || end_transaction_out || error_out) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", {data_valid_out, end_transaction_out, error_out}, 3'b000);
      end else begin
        e = sb_q.pop_front();
        case (e.kind)
          K_DATA: begin
            check("rd_flags", {data_valid_out, end_transaction_out, error_out}, 3'b100);
            check("rd_data", address_data_out, e.data);
          end
          K_END:  check("rdend_flags", {data_valid_out, end_transaction_out, error_out}, 3'b010);
          default: check("err_flags", {data_valid_out, end_transaction_out, error_out}, 3'b011);
        endcase
        check("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 600) begin
      step();
      n++;
    end
    check("sb_drain_empty", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) step();
  endtask

  // Write burst: nsend beats held valid; end with last beat or one cycle later.
  // rst_after>0 asserts reset in place of beat rst_after.
  task automatic do_write(input int word, input int bsz, input int nsend,
                          input bit end_with_last, input bit rand_be, input int rst_after);
    int remaining;
    int w;
    logic [31:0] d;
    logic [3:0]  be;
    wbeat_t      wb;
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b0;
    address_data_in      = BASE | (word << 2);
    burst_size_in        = bsz[7:0];
    step();
    begin_transaction_in = 1'b0;
    remaining = bsz + 1;
    w = word;
    for (int b = 0; b < nsend; b++) begin
      if (dir_q.size() > 0) begin
        wb = dir_q.pop_front();
        d  = wb.data;
        be = wb.be;
      end else begin
        d  = $urandom;
        be = rand_be ? 4'($urandom_range(0, 15)) : 4'hF;
      end
      data_valid_in   = 1'b1;
      address_data_in = d;
      byte_enables_in = be;
      if (rst_after > 0 && b == rst_after) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        data_valid_in = 1'b0;
        chk_all_zero("reset_outputs");
        return;
      end
      if (WS) begin
        check("busy_wait", busy_out, 1'b1);
        step();
      end
      check("busy_accept", busy_out, 1'b0);
      if (b == nsend - 1 && end_with_last) end_transaction_in = 1'b1;
      step();
      if (remaining > 0) begin
        model_write(w, d, be);
        w++;
        remaining--;
      end
    end
    data_valid_in = 1'b0;
    if (!end_with_last) begin
      check("busy_before_end", busy_out, WS);
      end_transaction_in = 1'b1;
      step();
    end
    end_transaction_in = 1'b0;
    check("busy_idle", busy_out, 1'b0);
    drain();
  endtask

  // Read burst; abort_after>0 raises end_transaction_in while that beat is shown.
  task automatic do_read(input int word, input int bsz, input int abort_after);
    int c;
    int n;
    exp_t e;
    n = bsz + 1;
    c = cyc;
    for (int j = 0; j < n; j++) begin
      if (abort_after == 0 || j < abort_after) begin
        e.kind = K_DATA; e.data = model_mem[word + j]; e.cyc = c + 2 + j * STEP;
        sb_q.push_back(e);
      end
    end
    if (abort_after == 0) begin
      e.kind = K_END; e.data = 32'h0; e.cyc = c + 2 + (n - 1) * STEP + 1;
      sb_q.push_back(e);
    end
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = BASE | (word << 2);
    burst_size_in        = bsz[7:0];
    step();
    begin_transaction_in = 1'b0;
    read_n_write_in      = 1'b0;
    address_data_in      = 32'h0;
    if (abort_after > 0) begin
      while (cyc < c + 2 + (abort_after - 1) * STEP) step();
      end_transaction_in = 1'b1;
      step();
      end_transaction_in = 1'b0;
      check("abort_quiet", {data_valid_out, end_transaction_out}, 2'b00);
    end
    drain();
  endtask

  // Erroring begin; for writes, data beats are offered afterwards and must be dropped.
  task automatic do_err(input logic [31:0] addr, input bit rnw, input int bsz);
    exp_t e;
    e.kind = K_ERR; e.data = 32'h0; e.cyc = cyc + 2;
    sb_q.push_back(e);
    begin_transaction_in = 1'b1;
    read_n_write_in      = rnw;
    address_data_in      = addr;
    burst_size_in        = bsz[7:0];
    step();
    begin_transaction_in = 1'b0;
    read_n_write_in      = 1'b0;
    data_valid_in        = !rnw;
    byte_enables_in      = 4'hF;
    repeat (3) begin
      address_data_in = $urandom;
      step();
    end
    data_valid_in = 1'b0;
    drain();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int word, bsz, op, nsend;
    wbeat_t wb;
    repeat (3) step();
    chk_all_zero("reset_state");
    reset = 1'b0;
    step();
    chk_all_zero("idle_after_reset");

    // Prefill the regions used below so every read has a known expectation.
    do_write(0, 63, 64, 1'b1, 1'b0, 0);
    do_write(1000, 23, 24, 1'b0, 1'b0, 0);

    // Write then read back at 0x5000_0010.
    for (int i = 1; i <= 4; i++) begin
      wb.data = 32'(i * 17); wb.be = 4'hF; dir_q.push_back(wb);
    end
    do_write(4, 3, 4, 1'b0, 1'b0, 0);
    do_read(4, 3, 0);

    // Byte enables.
    wb.data = 32'hAABB_CCDD; wb.be = 4'hF;    dir_q.push_back(wb);
    do_write(0, 0, 1, 1'b1, 1'b0, 0);
    wb.data = 32'h1122_3344; wb.be = 4'b0101; dir_q.push_back(wb);
    do_write(0, 0, 1, 1'b1, 1'b0, 0);
    check("be_model", model_mem[0], 32'hAA22_CC44);
    do_read(0, 0, 0);

    // Window overrun and boundary reads.
    do_err(BASE | (32'd1020 << 2), 1'b0, 7);
    do_read(1016, 7, 0);
    do_read(1023, 0, 0);

    // Misaligned and foreign addresses.
    do_err(32'h5000_0002, 1'b1, 0);
    begin_transaction_in = 1'b1;
    read_n_write_in      = 1'b1;
    address_data_in      = 32'h4000_0000;
    burst_size_in        = 8'd3;
    step();
    begin_transaction_in = 1'b0;
    read_n_write_in      = 1'b0;
    repeat (6) begin
      chk_all_zero("foreign_quiet");
      step();
    end

    // Read abort after the third beat, then reset mid-write.
    do_read(0, 15, 3);
    do_write(50, 3, 4, 1'b0, 1'b0, 2);
    repeat (2) step();
    do_read(50, 3, 0);

    // Random mix.
    for (int t = 0; t < 40; t++) begin
      op = $urandom_range(0, 2);
      if (op == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          word = $urandom_range(0, 47);
          bsz  = $urandom_range(0, 15);
        end else begin
          word = $urandom_range(1000, 1023);
          bsz  = $urandom_range(0, 1023 - word);
        end
        do_read(word, bsz, 0);
      end else if (op == 1) begin
        word  = $urandom_range(0, 47);
        bsz   = $urandom_range(0, 15);
        nsend = $urandom_range(1, bsz + 3);
        do_write(word, bsz, nsend, 1'($urandom_range(0, 1)), 1'b1, 0);
      end else begin
        if ($urandom_range(0, 1) == 1) begin
          word = $urandom_range(0, 47);
          do_err(BASE | (word << 2) | 32'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 2);
        end else begin
          word = $urandom_range(1000, 1023);
          do_err(BASE | (word << 2), 1'($urandom_range(0, 1)), $urandom_range(1024 - word, 255));
        end
      end
    end

    // Final readback of both regions against the model.
    do_read(0, 63, 0);
    do_read(1000, 23, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
